lab62_soc_multi_timer: RTL and testbench
========================================

Name: lab62_soc_multi_timer

Overview:
- Parametrised successor to the single interval timer: NUM_CH independent down-counting channels behind one Avalon-MM slave port.
- Each channel has a configurable counter width, a one-shot or continuous mode, a snapshot register, and its own interrupt.
- Sits on the SoC peripheral bus next to the other lab62_soc peripherals.
- Drives a combined irq to the CPU interrupt controller and exposes a per-channel irq vector.

Parameters:
- NUM_CH, 4, number of timer channels (1..8).
- COUNT_W, 32, counter and period width in bits (8..DATA_W).
- DATA_W, 32, Avalon data width.
- RESET_PERIOD, 49999, reset value of every period register and counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- address  in  $clog2(NUM_CH)+2  word address; [top:2] = channel, [1:0] = register
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  DATA_W  write data
- readdata  out  DATA_W  registered read data
- irq  out  1  OR of irq_vec
- irq_vec  out  NUM_CH  per-channel interrupt

Behaviour:
- Reset, sampled on the clk edge while reset_n=0:
  - counter = period = RESET_PERIOD; run = 0; TO = 0; control = 0; snapshot = 0.
  - readdata = 0; irq = 0; irq_vec = 0.
- Register map per channel (offset within the 4-word block):
  - 0 STATUS: bit0 TO, bit1 RUN. Any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START (strobe), bit3 STOP (strobe). Bits 3:0 are stored.
  - 2 PERIOD: COUNT_W bits.
  - 3 SNAP: any write captures the counter; a read returns the captured value.
- Unused upper bits read 0. A channel index >= NUM_CH reads 0 and ignores writes.
- Read latency is 1 cycle: readdata is registered every cycle from the address mux; there are no wait states.
- Write acceptance: chipselect && !write_n, single cycle.
- Counting:
  - While RUN=1 the counter decrements by 1 per cycle (see the optional feature).
  - At zero, the counter reloads the period on the next cycle.
  - A TO event occurs when the counter is 0 and was not 0 the previous cycle; it sets TO.
- One-shot (CONT=0): RUN clears in the cycle the counter is 0. The counter is still reloaded with the period.
- Continuous (CONT=1): runs until STOP.
- PERIOD write: sets force_reload for the next cycle. That cycle the counter loads the new period and RUN clears; software must restart the channel.
- START and STOP in the same control write: START wins and RUN=1.
- START while already running: no reload; counting continues.
- TO clear and a TO event in the same cycle: the clear wins.
- PERIOD=0: the counter stays at 0; one TO event on entry only; one-shot stops immediately.
- irq_vec[i] = TO[i] & ITO[i], combinational from registered state. irq = |irq_vec.
- Reset asserted mid-count aborts every channel to reset values on that edge. There are no partial states.
- Channels are fully independent; simultaneous accesses never occur, because there is a single port.

Optional Feature:
- Macro: MULTI_TIMER_PRESCALE_EN.
- Defined:
  - CONTROL bits [15:8] hold PRESC (reset 0).
  - A per-channel 8-bit prescale counter decrements the main counter only when it reaches PRESC, then returns to 0, giving a tick every PRESC+1 cycles.
  - The prescale counter clears on START, on force_reload, and on main-counter reload.
- Undefined: bits [15:8] read 0 and writes to them are ignored; the counter ticks every cycle.

Decomposition:
- Package lab62_soc_multi_timer_pkg:
  - register offset constants REG_STATUS/REG_CONTROL/REG_PERIOD/REG_SNAP;
  - control bit indices CTL_ITO/CTL_CONT/CTL_START/CTL_STOP;
  - status bit indices ST_TO/ST_RUN;
  - PRESC field position.
- Sub-module lab62_soc_multi_timer_ch:
  - one channel (counter, period, control, snapshot, TO edge detect, prescaler);
  - instantiated NUM_CH times by a generate loop.
- The top level does address decode, the read mux, the readdata register and the irq reduce.

Test Plan:
- Reset, then read ch0 PERIOD → readdata 49999 one cycle after the read; STATUS → 0; irq=0.
- ch1: PERIOD=9, CONTROL=0b0011|START (0x7):
  - TO sets 10 cycles after the counter reload;
  - irq_vec[1]=1 and irq=1; RUN stays 1;
  - a STATUS write clears irq next cycle.
- ch2 one-shot: PERIOD=4, CONTROL=START|ITO (0x5) → a single TO after 5 ticks, then RUN=0, counter=4, and no further TO for 50 cycles.
- ch0 running continuous: write PERIOD=100 mid-count → next cycle counter=100, RUN=0. Write SNAP 3 cycles later → SNAP reads 100.
- Same-cycle collision:
  - status write coincident with a TO event → TO=0;
  - CONTROL write 0xC (START|STOP) → RUN=1.
- With MULTI_TIMER_PRESCALE_EN: PERIOD=3, PRESC=1, CONT → TO every 8 cycles. Without the macro, the same writes give TO every 4 cycles and CONTROL reads back 0x3.

Source files
------------

// File: rtl/lab62_soc_multi_timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package lab62_soc_multi_timer_pkg;

    // Word offsets inside each channel's 4-word register block
    typedef enum logic [1:0] {
        REG_STATUS  = 2'd0,
        REG_CONTROL = 2'd1,
        REG_PERIOD  = 2'd2,
        REG_SNAP    = 2'd3
    } reg_e;

    // CONTROL bit positions; START and STOP act as strobes but are still stored
    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    // STATUS bit positions
    localparam int ST_TO  = 0;
    localparam int ST_RUN = 1;

    // Prescaler field inside CONTROL (only live with MULTI_TIMER_PRESCALE_EN)
    localparam int PRESC_LSB = 8;
    localparam int PRESC_W   = 8;

endpackage

// File: rtl/lab62_soc_multi_timer_ch.sv
// One timer channel: down counter, period, control, snapshot, TO edge detect, optional prescaler (MULTI_TIMER_PRESCALE_EN).
// Latency: register writes take effect on the next clk edge; rdata is combinational from state.
// Backpressure: none, every bus write is accepted in its single cycle.
module lab62_soc_multi_timer_ch
    import lab62_soc_multi_timer_pkg::*;
#(
    parameter int COUNT_W      = 32,
    parameter int DATA_W       = 32,
    parameter int RESET_PERIOD = 49999
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  reg_e              reg_sel,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              irq
);

    logic [COUNT_W-1:0] counter;
    logic [COUNT_W-1:0] period;
    logic [COUNT_W-1:0] snapshot;
    logic [3:0]         ctl;
    logic               run;
    logic               to_flag;
    logic               prev_zero;
    logic               force_reload;
    logic               tick;
    logic [PRESC_W-1:0] presc_rd;

    logic wr_status, wr_control, wr_period, wr_snap;
    logic start, stop, cnt_zero, to_event;

    assign wr_status  = wr_en && (reg_sel == REG_STATUS);
    assign wr_control = wr_en && (reg_sel == REG_CONTROL);
    assign wr_period  = wr_en && (reg_sel == REG_PERIOD);
    assign wr_snap    = wr_en && (reg_sel == REG_SNAP);
    assign start      = wr_control && wdata[CTL_START];
    assign stop       = wr_control && wdata[CTL_STOP];
    assign cnt_zero   = (counter == '0);
    assign to_event   = cnt_zero && !prev_zero;

`ifdef MULTI_TIMER_PRESCALE_EN
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_cnt;

    assign tick     = (presc_cnt == presc);
    assign presc_rd = presc;

    // Prescale divisor lives in CONTROL[15:8]
    always_ff @(posedge clk) begin
        if (!reset_n)
            presc <= '0;
        else if (wr_control)
            presc <= wdata[PRESC_LSB +: PRESC_W];
    end

    // Free-running prescale counter; wraps on tick and restarts on START/force reload
    always_ff @(posedge clk) begin
        if (!reset_n)
            presc_cnt <= '0;
        else if (start || force_reload || tick)
            presc_cnt <= '0;
        else
            presc_cnt <= presc_cnt + PRESC_W'(1);
    end
`else
    assign tick     = 1'b1;
    assign presc_rd = '0;
`endif

    // Main counter: forced reload beats zero reload beats decrement
    always_ff @(posedge clk) begin
        if (!reset_n)
            counter <= COUNT_W'(RESET_PERIOD);
        else if (force_reload)
            counter <= period;
        else if (cnt_zero && tick)
            counter <= period;
        else if (run && tick)
            counter <= counter - COUNT_W'(1);
    end

    // RUN: START wins over every clearing source; one-shot drops at zero
    always_ff @(posedge clk) begin
        if (!reset_n)
            run <= 1'b0;
        else if (start)
            run <= 1'b1;
        else if (stop || force_reload || (cnt_zero && !ctl[CTL_CONT]))
            run <= 1'b0;
    end

    // TO flag on the first cycle at zero; a STATUS write clear takes priority
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            to_flag   <= 1'b0;
            prev_zero <= (RESET_PERIOD == 0);
        end else begin
            prev_zero <= cnt_zero;
            if (wr_status)
                to_flag <= 1'b0;
            else if (to_event)
                to_flag <= 1'b1;
        end
    end

    // Software-visible registers written over the bus
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            period       <= COUNT_W'(RESET_PERIOD);
            ctl          <= '0;
            snapshot     <= '0;
            force_reload <= 1'b0;
        end else begin
            force_reload <= wr_period;
            if (wr_period)
                period <= wdata[COUNT_W-1:0];
            if (wr_control)
                ctl <= wdata[3:0];
            if (wr_snap)
                snapshot <= counter;
        end
    end

    // Register read mux for this channel; unused bits are zero
    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_STATUS: begin
                rdata[ST_TO]  = to_flag;
                rdata[ST_RUN] = run;
            end
            REG_CONTROL: begin
                rdata[3:0]                   = ctl;
                rdata[PRESC_LSB +: PRESC_W]  = presc_rd;
            end
            REG_PERIOD: rdata[COUNT_W-1:0] = period;
            REG_SNAP:   rdata[COUNT_W-1:0] = snapshot;
            default:    rdata = '0;
        endcase
    end

    assign irq = to_flag & ctl[CTL_ITO];

    logic unused_wdata;
    assign unused_wdata = &{1'b0, wdata};

endmodule

// File: rtl/lab62_soc_multi_timer.sv
// NUM_CH-channel interval timer behind one Avalon-MM slave; optional prescaler via MULTI_TIMER_PRESCALE_EN.
// Latency: readdata registered one cycle after the address is presented; writes apply on the next edge.
// Backpressure: none, no wait states; every chipselect cycle completes immediately.
module lab62_soc_multi_timer
    import lab62_soc_multi_timer_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int COUNT_W      = 32,
    parameter int DATA_W       = 32,
    parameter int RESET_PERIOD = 49999
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [$clog2(NUM_CH)+1:0]   address,
    input  logic                        chipselect,
    input  logic                        write_n,
    input  logic [DATA_W-1:0]           writedata,
    output logic [DATA_W-1:0]           readdata,
    output logic                        irq,
    output logic [NUM_CH-1:0]           irq_vec
);

    localparam int ADDR_W = $clog2(NUM_CH) + 2;

    logic [ADDR_W-1:0] ch_idx;
    logic              wr_en;
    reg_e              reg_sel;
    logic [DATA_W-1:0] ch_rdata [NUM_CH];
    logic [DATA_W-1:0] rd_mux;

    assign ch_idx  = address >> 2;
    assign reg_sel = reg_e'(address[1:0]);
    assign wr_en   = chipselect && !write_n;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        lab62_soc_multi_timer_ch #(
            .COUNT_W      (COUNT_W),
            .DATA_W       (DATA_W),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_en   (wr_en && (ch_idx == ADDR_W'(g))),
            .reg_sel (reg_sel),
            .wdata   (writedata),
            .rdata   (ch_rdata[g]),
            .irq     (irq_vec[g])
        );
    end

    // Channel select for reads; an index past the last channel reads zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == ADDR_W'(i))
                rd_mux = ch_rdata[i];
        end
    end

    // readdata follows the address mux every cycle
    always_ff @(posedge clk) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= rd_mux;
    end

    assign irq = |irq_vec;

endmodule

// File: tb/tb_lab62_soc_multi_timer.sv
// Directed + random bus traffic against a behavioural timer model; every cycle compares readdata/irq.
// Latency: expects readdata one cycle after the address and register effects on the next edge.
// Backpressure: none expected from the DUT.
module tb_lab62_soc_multi_timer;

    localparam int NUM_CH       = 4;
    localparam int COUNT_W      = 32;
    localparam int DATA_W       = 32;
    localparam int RESET_PERIOD = 49999;
    localparam int ADDR_W       = 4;
`ifdef MULTI_TIMER_PRESCALE_EN
    localparam bit          PRESC_EN = 1'b1;
    localparam logic [15:0] CTL_MASK = 16'hFF0F;
`else
    localparam bit          PRESC_EN = 1'b0;
    localparam logic [15:0] CTL_MASK = 16'h000F;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [DATA_W-1:0] writedata = '0;
    logic [DATA_W-1:0] readdata;
    logic              irq;
    logic [NUM_CH-1:0] irq_vec;

    lab62_soc_multi_timer #(
        .NUM_CH(NUM_CH), .COUNT_W(COUNT_W), .DATA_W(DATA_W), .RESET_PERIOD(RESET_PERIOD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq(irq), .irq_vec(irq_vec)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: one record per channel, advanced once per clock edge
    logic [31:0] m_cnt  [NUM_CH];
    logic [31:0] m_per  [NUM_CH];
    logic [31:0] m_snap [NUM_CH];
    logic [15:0] m_ctl  [NUM_CH];
    logic [7:0]  m_pc   [NUM_CH];
    bit          m_run  [NUM_CH];
    bit          m_to   [NUM_CH];
    bit          m_prevz[NUM_CH];
    bit          m_fr   [NUM_CH];
    logic [31:0] m_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = RESET_PERIOD; m_per[i] = RESET_PERIOD; m_snap[i] = 0;
            m_ctl[i] = 0; m_pc[i] = 0; m_run[i] = 0; m_to[i] = 0;
            m_prevz[i] = 0; m_fr[i] = 0;
        end
        m_rd = 0;
    endtask

    function automatic logic [31:0] model_read(input int ch, input int rg);
        if (ch >= NUM_CH) return 0;
        case (rg)
            0: return {30'd0, m_run[ch], m_to[ch]};
            1: return {16'd0, m_ctl[ch]};
            2: return m_per[ch];
            default: return m_snap[ch];
        endcase
    endfunction

    function automatic logic [NUM_CH-1:0] model_irq();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = m_to[i] & m_ctl[i][0];
        return v;
    endfunction

    // Apply the timer rules for one edge using the inputs currently on the bus
    task automatic model_edge();
        int ch, rg, presc;
        bit wr, w, zero, tick, start, stop;
        logic [31:0] n_cnt;
        bit n_run, n_to;
        if (!reset_n) begin
            model_reset();
            return;
        end
        ch = int'(address[3:2]);
        rg = int'(address[1:0]);
        m_rd = model_read(ch, rg);
        wr = chipselect && !write_n;
        for (int i = 0; i < NUM_CH; i++) begin
            w     = wr && (ch == i);
            zero  = (m_cnt[i] == 0);
            presc = PRESC_EN ? int'(m_ctl[i][15:8]) : 0;
            tick  = (int'(m_pc[i]) == presc);
            start = w && rg == 1 && writedata[2];
            stop  = w && rg == 1 && writedata[3];
            if (m_fr[i] || (zero && tick)) n_cnt = m_per[i];
            else if (m_run[i] && tick)      n_cnt = m_cnt[i] - 1;
            else                            n_cnt = m_cnt[i];
            if (start) n_run = 1;
            else if (stop || m_fr[i] || (zero && !m_ctl[i][1])) n_run = 0;
            else n_run = m_run[i];
            if (w && rg == 0) n_to = 0;
            else if (zero && !m_prevz[i]) n_to = 1;
            else n_to = m_to[i];
            m_pc[i]    = (start || m_fr[i] || tick) ? 8'd0 : m_pc[i] + 8'd1;
            m_prevz[i] = zero;
            if (w && rg == 3) m_snap[i] = m_cnt[i];
            if (w && rg == 1) m_ctl[i] = writedata[15:0] & CTL_MASK;
            if (w && rg == 2) m_per[i] = writedata;
            m_fr[i]  = w && rg == 2;
            m_cnt[i] = n_cnt;
            m_run[i] = n_run;
            m_to[i]  = n_to;
        end
    endtask

    // One bus cycle: drive on negedge, advance model on posedge, compare 1 time unit later
    task automatic bus(input bit cs, input bit wn, input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = cs; write_n = wn; address = a; writedata = d;
        @(posedge clk);
        model_edge();
        #1;
        chk("readdata", readdata, m_rd);
        chk("irq_vec", {28'd0, irq_vec}, {28'd0, model_irq()});
        chk("irq", {31'd0, irq}, {31'd0, |model_irq()});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) bus(1'b0, 1'b1, address, 32'd0);
    endtask

    task automatic wr(input int ch, input int rg, input logic [31:0] d);
        bus(1'b1, 1'b0, 4'((ch << 2) | rg), d);
    endtask

    task automatic rd(input int ch, input int rg, output logic [31:0] v);
        bus(1'b1, 1'b1, 4'((ch << 2) | rg), 32'd0);
        v = readdata;
    endtask

    initial begin
        logic [31:0] v;
        int n, rises;
        bit prev;

        // Reset state
        model_reset();
        reset_n = 1'b0;
        idle(3);
        chk("reset_readdata", readdata, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;

        rd(0, 2, v); chk("ch0_period_reset", v, 32'd49999);
        rd(0, 0, v); chk("ch0_status_reset", v, 32'd0);

        // ch1 continuous with interrupt
        wr(1, 2, 9);
        wr(1, 1, 32'h7);
        n = 31;
        for (int k = 1; k <= 30; k++) begin
            idle(1);
            if (irq_vec[1]) begin n = k; break; end
        end
        chk("ch1_to_delay", n, 10);
        chk("ch1_irq", {31'd0, irq}, 32'd1);
        rd(1, 0, v); chk("ch1_status_to_run", v, 32'd3);
        wr(1, 0, 0);
        chk("ch1_irq_cleared", {28'd0, irq_vec}, 32'd0);

        // ch2 one-shot
        wr(2, 2, 4);
        wr(2, 1, 32'h5);
        n = 0; rises = 0; prev = irq_vec[2];
        for (int k = 1; k <= 60; k++) begin
            idle(1);
            if (irq_vec[2] && !prev) begin rises++; if (n == 0) n = k; end
            prev = irq_vec[2];
        end
        chk("ch2_first_to", n, 5);
        chk("ch2_to_count", rises, 1);
        rd(2, 0, v); chk("ch2_status_stopped", v, 32'd1);
        wr(2, 3, 0);
        rd(2, 3, v); chk("ch2_snap_reloaded", v, 32'd4);

        // ch0 period write while running continuous
        wr(0, 1, 32'h6);
        idle(5);
        wr(0, 2, 100);
        idle(3);
        wr(0, 3, 0);
        rd(0, 3, v); chk("ch0_snap_after_period", v, 32'd100);
        rd(0, 0, v); chk("ch0_status_stopped", v, 32'd0);

        // TO clear colliding with a TO event on ch1
        wr(1, 0, 0);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            if (m_cnt[1] == 0 && !m_prevz[1]) begin n = 1; break; end
            idle(1);
        end
        chk("ch1_found_event", n, 1);
        wr(1, 0, 0);
        rd(1, 0, v); chk("ch1_clear_wins", v, 32'd2);

        // START and STOP together
        wr(3, 1, 32'hC);
        rd(3, 0, v); chk("ch3_start_wins", v, 32'd2);

        // Prescaler (or plain) interval on ch3
        wr(3, 2, 3);
        wr(3, 1, 32'h107);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            idle(1);
            if (irq_vec[3]) begin n = 1; break; end
        end
        chk("ch3_first_to", n, 1);
        wr(3, 0, 0);
        n = 41;
        for (int k = 2; k <= 40; k++) begin
            idle(1);
            if (irq_vec[3]) begin n = k; break; end
        end
        chk("ch3_to_interval", n, PRESC_EN ? 8 : 4);
        wr(3, 1, 32'h103);
        rd(3, 1, v); chk("ch3_control_readback", v, PRESC_EN ? 32'h103 : 32'h3);

        // Random traffic, reset pulse midway
        for (int k = 0; k < 400; k++) begin
            int ch, rg;
            logic [31:0] d;
            if (k == 200) begin
                reset_n = 1'b0;
                idle(2);
                reset_n = 1'b1;
                rd(0, 2, v); chk("midreset_period", v, 32'd49999);
            end
            ch = $urandom_range(0, NUM_CH - 1);
            rg = $urandom_range(0, 3);
            case (rg)
                1: d = $urandom & 32'hFFFF;
                2: d = $urandom_range(0, 12);
                default: d = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: idle(1);
                1: bus(1'b1, 1'b1, 4'((ch << 2) | rg), 32'd0);
                default: wr(ch, rg, d);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
